// File: rtl/mem_pattern_tester.sv
// mem_pattern_tester: runs a write-then-verify pass over memory addresses
// 0..DEPTH-1. Each word is written with a pattern selected by mode and then
// read back one address at a time. Mismatches are counted, and the first
// failing address is recorded.
module mem_pattern_tester #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] PATTERN = DATA_WIDTH'(16'h5A5A),
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  enable,
  output logic                  read_write,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_oe,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_ALT0  = 2'd0;
  localparam logic [1:0] MODE_ALT1  = 2'd1;
  localparam logic [1:0] MODE_ADDR  = 2'd2;

  // Highest tested address. It is compared against and never incremented
  // past, so DEPTH == 2**ADDR_WIDTH cannot wrap.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // The wait counter counts down from READ_LATENCY-1 to 0. Zero marks the
  // edge where data_in is valid.
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);

  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [CNT_W-1:0]        wait_cnt;
  logic [1:0]              mode_q;
  logic                    last_addr;
  logic                    wait_last;
  logic [DATA_WIDTH-1:0]   expected;

  // Pattern word that address a must hold for the selected mode.
  function automatic logic [DATA_WIDTH-1:0] expected_word(
    input logic [1:0]            m,
    input logic [ADDR_WIDTH-1:0] a
  );
    case (m)
      MODE_ALT0: return a[0] ? ~PATTERN : PATTERN;
      MODE_ALT1: return a[0] ? PATTERN : ~PATTERN;
      MODE_ADDR: return DATA_WIDTH'(a);
      default:   return PATTERN;
    endcase
  endfunction

  assign last_addr = (addr == LAST_ADDR);
  assign wait_last = (wait_cnt == '0);
  assign expected  = expected_word(mode_q, addr);
  assign address   = addr;

  // State register. Reset takes priority over every transition.
  // NOTE: sequential state uses non-blocking (<=) so all registers update
  // from the same pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic. Start is accepted only when not busy.
  // NOTE: state_next gets a default before the case, so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE,
      S_DONE:  if (start) state_next = S_WRITE;
      S_WRITE: if (last_addr) state_next = S_READ;
      S_READ:  state_next = S_WAIT;
      S_WAIT:  if (wait_last) state_next = last_addr ? S_DONE : S_READ;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: address walk, latency counter, mode latch and error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr            <= '0;
      wait_cnt        <= '0;
      mode_q          <= '0;
      err_count       <= '0;
      first_fail_addr <= '0;
    end else begin
      case (state)
        S_IDLE,
        S_DONE: begin
          if (start) begin
            addr            <= '0;
            mode_q          <= mode;
            err_count       <= '0;
            first_fail_addr <= '0;
          end
        end
        S_WRITE: begin
          addr <= last_addr ? '0 : addr + ADDR_WIDTH'(1);
        end
        S_READ: begin
          wait_cnt <= LAT_LOAD;
        end
        S_WAIT: begin
          if (!wait_last) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end else begin
            if (data_in != expected) begin
              // err_count still being zero means this is the first miss.
              if (err_count == '0) first_fail_addr <= addr;
              if (err_count != ERR_MAX) err_count <= err_count + ERR_WIDTH'(1);
            end
            if (!last_addr) addr <= addr + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the current state. Memory is driven only in WRITE and READ.
  always_comb begin
    enable     = 1'b0;
    read_write = 1'b1;
    data_oe    = 1'b0;
    data_out   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    pass       = 1'b0;
    case (state)
      S_WRITE: begin
        enable     = 1'b1;
        read_write = 1'b0;
        data_oe    = 1'b1;
        data_out   = expected;
        busy       = 1'b1;
      end
      S_READ: begin
        enable = 1'b1;
        busy   = 1'b1;
      end
      S_WAIT: busy = 1'b1;
      S_DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Bench for mem_pattern_tester. It uses two instances.
// Instance A: DEPTH=4, latency 1, 2-bit error counter.
// Instance B: ADDR_WIDTH=3, DEPTH=8, latency 3 (the full address space).
// Each instance has a behavioural memory with an injectable read fault.
module tb_mem_pattern_tester;

  localparam logic [15:0] PAT = 16'h5A5A;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [1:0] mode = 2'd0;

  always #5 clk = ~clk;

  // Instance A signals
  logic [15:0] addr_a, dout_a, din_a, ff_a;
  logic        en_a, rw_a, oe_a, busy_a, done_a, pass_a;
  logic [1:0]  err_a;
  // Instance B signals
  logic [2:0]  addr_b, ff_b;
  logic [15:0] dout_b, din_b, err_b;
  logic        en_b, rw_b, oe_b, busy_b, done_b, pass_b;

  mem_pattern_tester #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(4),
    .READ_LATENCY(1), .PATTERN(16'h5A5A), .ERR_WIDTH(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode),
    .address(addr_a), .enable(en_a), .read_write(rw_a), .data_out(dout_a),
    .data_oe(oe_a), .data_in(din_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_fail_addr(ff_a));

  mem_pattern_tester #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .DEPTH(8),
    .READ_LATENCY(3), .PATTERN(16'h5A5A), .ERR_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode),
    .address(addr_b), .enable(en_b), .read_write(rw_b), .data_out(dout_b),
    .data_oe(oe_b), .data_in(din_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_fail_addr(ff_b));

  // Read fault: all-zero memory, or OR-ing f_mask into the word at f_addr.
  bit          f_zero = 1'b0;
  int          f_addr = 0;
  logic [15:0] f_mask = '0;

  function automatic logic [15:0] rd_val(input logic [15:0] stored, input int a);
    if (f_zero) return 16'h0000;
    return stored | ((a == f_addr) ? f_mask : 16'h0000);
  endfunction

  // Memory models with fixed read latency (1 for A, 3 for B).
  logic [15:0] mem_a [0:3];
  logic [15:0] mem_b [0:7];
  logic [15:0] rd_a = 16'hDEAD;
  logic [15:0] pb [0:2];
  initial for (int i = 0; i < 3; i++) pb[i] = 16'hDEAD;

  always @(posedge clk) begin
    if (en_a && !rw_a) mem_a[addr_a[1:0]] <= dout_a;
    rd_a <= (en_a && rw_a) ? rd_val(mem_a[addr_a[1:0]], int'(addr_a)) : 16'hDEAD;
    if (en_b && !rw_b) mem_b[addr_b] <= dout_b;
    pb[0] <= (en_b && rw_b) ? rd_val(mem_b[addr_b], int'(addr_b)) : 16'hDEAD;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign din_a = rd_a;
  assign din_b = pb[2];

  // Select the outputs of the instance under test.
  int cur = 0;
  logic [15:0] m_addr, m_dout, m_err, m_ff;
  logic        m_en, m_rw, m_oe, m_busy, m_done, m_pass;
  always_comb begin
    m_addr = (cur != 0) ? 16'(addr_b) : addr_a;
    m_dout = (cur != 0) ? dout_b : dout_a;
    m_err  = (cur != 0) ? err_b : 16'(err_a);
    m_ff   = (cur != 0) ? 16'(ff_b) : ff_a;
    m_en   = (cur != 0) ? en_b : en_a;
    m_rw   = (cur != 0) ? rw_b : rw_a;
    m_oe   = (cur != 0) ? oe_b : oe_a;
    m_busy = (cur != 0) ? busy_b : busy_a;
    m_done = (cur != 0) ? done_b : done_a;
    m_pass = (cur != 0) ? pass_b : pass_a;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the pattern word for each address and mode.
  function automatic logic [15:0] exp_word(input int m, input int a);
    case (m)
      0: return ((a & 1) != 0) ? ~PAT : PAT;
      1: return ((a & 1) != 0) ? PAT : ~PAT;
      2: return 16'(a);
      default: return PAT;
    endcase
  endfunction

  // Reference model: error count and first failing address for a whole test.
  task automatic model(input int inst, input int m, output int e, output int ff);
    int depth, emax;
    logic [15:0] w;
    depth = (inst != 0) ? 8 : 4;
    emax  = (inst != 0) ? 65535 : 3;
    e = 0; ff = 0;
    for (int a = 0; a < depth; a++) begin
      w = exp_word(m, a);
      if (rd_val(w, a) != w) begin
        if (e == 0) ff = a;
        if (e < emax) e++;
      end
    end
  endtask

  // Runs one test. extra != 0 pulses start again during that cycle of the test.
  task automatic run_test(input string nm, input int inst, input int m, input int extra,
                          input int exp_err, input int exp_ff, input bit exp_pass);
    int depth, lat, cyc, nwr, bad, post;
    depth = (inst != 0) ? 8 : 4;
    lat   = (inst != 0) ? 3 : 1;
    cur   = inst;
    @(negedge clk);
    mode = 2'(m);
    start_a = (inst == 0);
    start_b = (inst != 0);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    cyc = 1; nwr = 0; bad = 0;
    while (!m_done && cyc < 400) begin
      if (m_en && !m_rw) begin
        if (m_addr != 16'(nwr) || m_dout != exp_word(m, nwr) || cyc != nwr + 1) bad++;
        nwr++;
      end
      if (m_oe != (m_en && !m_rw)) bad++;
      if (!m_oe && m_dout != 16'h0) bad++;
      if (m_en && m_addr >= 16'(depth)) bad++;
      if (!m_busy) bad++;
      if (extra != 0 && cyc == extra) begin
        if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0; start_b = 1'b0;
    check({nm, " done_cycle"}, cyc, depth * (2 + lat) + 1);
    check({nm, " write_count"}, nwr, depth);
    check({nm, " bus_protocol"}, bad, 0);
    check({nm, " err_count"}, m_err, exp_err);
    check({nm, " first_fail_addr"}, m_ff, exp_ff);
    check({nm, " pass"}, m_pass, exp_pass);
    post = 0;
    for (int i = 0; i < 3; i++) begin
      if (m_en || !m_done || m_busy) post++;
      @(negedge clk);
    end
    check({nm, " idle_after_done"}, post, 0);
  endtask

  typedef struct {
    int          inst;
    int          mode;
    bit          zero;
    int          faddr;
    logic [15:0] fmask;
    int          extra;
    int          exp_err;
    int          exp_ff;
    bit          exp_pass;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int e, ff, cyc, inst, m, quiet;

    vecs[0] = '{0, 0, 1'b0, 0, 16'h0000, 0, 0, 0, 1'b1}; // ideal memory, mode 0
    vecs[1] = '{0, 0, 1'b0, 2, 16'h0001, 0, 1, 2, 1'b0}; // addr 2 bit0 stuck at 1
    vecs[2] = '{0, 3, 1'b1, 0, 16'h0000, 0, 3, 0, 1'b0}; // zeros, saturating at 3
    vecs[3] = '{0, 1, 1'b0, 1, 16'h0001, 0, 1, 1, 1'b0};
    vecs[4] = '{0, 2, 1'b0, 3, 16'h0001, 0, 0, 0, 1'b1}; // stuck bit already 1
    vecs[5] = '{0, 2, 1'b1, 0, 16'h0000, 0, 3, 1, 1'b0};
    vecs[6] = '{0, 0, 1'b0, 0, 16'h0000, 2, 0, 0, 1'b1}; // start re-pulsed mid-WRITE
    vecs[7] = '{1, 2, 1'b0, 0, 16'h0000, 0, 0, 0, 1'b1}; // full 3-bit space, latency 3
    vecs[8] = '{1, 2, 1'b1, 0, 16'h0000, 0, 7, 1, 1'b0};
    vecs[9] = '{1, 3, 1'b0, 7, 16'h8000, 0, 1, 7, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    cur = 0;
    check("reset address", m_addr, 0);
    check("reset enable", m_en, 0);
    check("reset read_write", m_rw, 1);
    check("reset data_oe", m_oe, 0);
    check("reset data_out", m_dout, 0);
    check("reset busy", m_busy, 0);
    check("reset done", m_done, 0);
    check("reset pass", m_pass, 0);
    check("reset err_count", m_err, 0);
    check("reset first_fail", m_ff, 0);

    foreach (vecs[i]) begin
      f_zero = vecs[i].zero; f_addr = vecs[i].faddr; f_mask = vecs[i].fmask;
      run_test($sformatf("vec%0d", i), vecs[i].inst, vecs[i].mode, vecs[i].extra,
               vecs[i].exp_err, vecs[i].exp_ff, vecs[i].exp_pass);
    end

    // Reset during a READ cycle abandons the test.
    f_zero = 1'b0; f_mask = '0; cur = 0;
    @(negedge clk); mode = 2'd0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    cyc = 0;
    while (!(en_a && rw_a) && cyc < 50) begin @(negedge clk); cyc++; end
    check("reach READ", (en_a && rw_a), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midread_rst enable", m_en, 0);
    check("midread_rst busy", m_busy, 0);
    check("midread_rst address", m_addr, 0);
    check("midread_rst done", m_done, 0);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_en || m_busy) quiet++;
      @(negedge clk);
    end
    check("midread_rst no_access", quiet, 0);
    run_test("post_reset", 0, 0, 0, 0, 0, 1'b1);

    // Randomized tests checked against the reference model.
    for (int i = 0; i < 16; i++) begin
      inst   = int'($urandom_range(0, 1));
      m      = int'($urandom_range(0, 3));
      f_zero = ($urandom_range(0, 3) == 0);
      f_addr = int'($urandom_range(0, (inst != 0) ? 7 : 3));
      f_mask = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      model(inst, m, e, ff);
      run_test($sformatf("rand%0d", i), inst, m, 0, e, ff, e == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_pattern_tester.md
MEM_PATTERN_TESTER -- requirements
Module: mem_pattern_tester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory data width.
REQ-003 SHALL have parameter DEPTH, default 16, number of locations tested (addresses 0..DEPTH-1), 2 <= DEPTH <= 2^ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from read request sampled by memory to data_in valid, >= 1.
REQ-005 SHALL have parameter PATTERN, default 16'h5A5A (DATA_WIDTH bits), base test word.
REQ-006 SHALL have parameter ERR_WIDTH, default 16, error counter width.
REQ-007 SHALL have ports: clk, input, 1, the single clock; all logic on the rising edge.
REQ-008 SHALL have ports: reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have ports: start, input, 1, one-cycle request to begin a test.
REQ-010 SHALL have ports: mode, input, 2, pattern select, sampled when start is accepted.
REQ-011 SHALL have ports: address, output, ADDR_WIDTH, memory address.
REQ-012 SHALL have ports: enable, output, 1, memory access strobe.
REQ-013 SHALL have ports: read_write, output, 1, 1 = read, 0 = write.
REQ-014 SHALL have ports: data_out, output, DATA_WIDTH, write data to memory.
REQ-015 SHALL have ports: data_oe, output, 1, high only in write cycles; data_out SHALL be 0 when data_oe is low.
REQ-016 SHALL have ports: data_in, input, DATA_WIDTH, read data from memory.
REQ-017 SHALL have ports: busy, done, pass, output, 1 each; err_count, output, ERR_WIDTH; first_fail_addr, output, ADDR_WIDTH.

Function
REQ-018 SHALL implement states IDLE, WRITE, READ, WAIT, DONE.
REQ-019 SHALL leave IDLE or DONE when start=1 at an edge, entering WRITE at address 0 and clearing done, pass, err_count and first_fail_addr.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL, in each WRITE cycle, drive enable=1, read_write=0, data_oe=1, data_out=expected(address).
REQ-022 SHALL increment the address after each write; after address DEPTH-1, go to READ at address 0, with no address wrap or overflow when DEPTH=2^ADDR_WIDTH.
REQ-023 SHALL, in READ, drive enable=1 and read_write=1 for exactly one cycle, then enter WAIT for READ_LATENCY cycles with enable=0 and address held.
REQ-024 SHALL sample data_in and compare it to expected(address) at the last WAIT edge, then advance to the next READ, or to DONE after address DEPTH-1.
REQ-025 SHALL compute expected(a) by mode: 0 = a[0] ? ~PATTERN : PATTERN; 1 = a[0] ? PATTERN : ~PATTERN; 2 = a zero-extended or truncated to DATA_WIDTH; 3 = PATTERN for all a.
REQ-026 SHALL, on a mismatch, increment err_count, saturating at 2^ERR_WIDTH-1, and load first_fail_addr only on the first mismatch of the test.
REQ-027 SHALL hold busy=1 in WRITE, READ and WAIT.
REQ-028 SHALL hold done=1 in DONE until the next accepted start or reset, with pass = (err_count==0) valid while done=1.
REQ-029 SHALL keep enable=0 in IDLE and DONE.
REQ-030 SHALL start a test at edge E0 with the first write in cycle 1, the last compare at the end of cycle DEPTH*(2+READ_LATENCY), and done=1 in the following cycle.

Reset
REQ-031 SHALL, when reset=1 at an edge, force state IDLE and drive address=0, enable=0, read_write=1, data_oe=0, data_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_addr=0 from the next cycle.
REQ-032 SHALL give reset priority over start.
REQ-033 SHALL, on reset mid-test, abandon the test with no further memory accesses.

Verification
REQ-034 SHALL verify, with DEPTH=4, LAT=1, mode 0 and an ideal memory model: writes 0:5A5A, 1:A5A5, 2:5A5A, 3:A5A5 in cycles 1-4; done=1 in cycle 13; pass=1; err_count=0.
REQ-035 SHALL verify, with the same setup and address 2 bit 0 stuck at 1: err_count=1, first_fail_addr=2, pass=0.
REQ-036 SHALL verify, with mode 2, ADDR_WIDTH=3, DEPTH=8 and READ_LATENCY=3: addresses 0..7 written with data 0..7, no access beyond 7, done=1 in cycle 41.
REQ-037 SHALL verify, with ERR_WIDTH=2 and a memory returning all zeros in mode 3: err_count saturates at 3 and first_fail_addr=0.
REQ-038 SHALL verify that start pulsed during WRITE has no effect, and that reset asserted mid-READ gives enable=0 and busy=0 on the next cycle, with a later start running a full clean test.
